// File: rtl/viterbi_frame_ctrl.sv
// Viterbi decoder frame sequencer.
// Accepts received symbol pairs and strobes the branch-metric and ACS stages.
// It writes survivor memory one cycle behind each accepted step, then sweeps
// traceback from the last step back to step 0. The traceback bits are
// buffered and streamed out in forward (decoded) order with a last-bit marker.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int AW        = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    in_rx_pair,
    output logic          in_ready,
    output logic [1:0]    bmc_rx_pair,
    output logic          acs_en,
    output logic          pm_init,
    output logic          sm_wr_en,
    output logic          sm_rd_en,
    output logic [AW-1:0] sm_addr,
    output logic          tb_start,
    input  logic          tb_bit_valid,
    input  logic          tb_bit,
    output logic          out_valid,
    output logic          out_bit,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_ACS   = 2'd0,
        S_DRAIN = 2'd1,
        S_TB    = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t               state_q, state_d;
    logic [AW-1:0]        step_q, step_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic                 rd_act_q, rd_act_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic                 rd_dly_v_q, rd_dly_v_d;
    logic [AW-1:0]        rd_dly_addr_q, rd_dly_addr_d;
    logic [FRAME_LEN-1:0] bit_buf_q, bit_buf_d;

    logic accept;

    // A symbol beat is taken only in ACS and never while reset is sampled.
    assign accept = !rst && (state_q == S_ACS) && in_valid;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_ACS;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, survivor-write pipeline and traceback read-delay registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q        <= '0;
            idx_q         <= '0;
            wr_pend_q     <= 1'b0;
            wr_addr_q     <= '0;
            rd_act_q      <= 1'b0;
            rd_addr_q     <= '0;
            rd_dly_v_q    <= 1'b0;
            rd_dly_addr_q <= '0;
        end else begin
            step_q        <= step_d;
            idx_q         <= idx_d;
            wr_pend_q     <= wr_pend_d;
            wr_addr_q     <= wr_addr_d;
            rd_act_q      <= rd_act_d;
            rd_addr_q     <= rd_addr_d;
            rd_dly_v_q    <= rd_dly_v_d;
            rd_dly_addr_q <= rd_dly_addr_d;
        end
    end

    // Decoded-bit buffer.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is left out of reset on purpose; every entry is
        // rewritten by traceback before OUT can read it.
        bit_buf_q <= bit_buf_d;
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d       = state_q;
        step_d        = step_q;
        idx_d         = idx_q;
        wr_pend_d     = 1'b0;
        wr_addr_d     = wr_addr_q;
        rd_act_d      = rd_act_q;
        rd_addr_d     = rd_addr_q;
        rd_dly_v_d    = 1'b0;
        rd_dly_addr_d = rd_dly_addr_q;
        bit_buf_d     = bit_buf_q;

        unique case (state_q)
            S_ACS: begin
                if (accept) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = step_q;
                    if (step_q == LAST) begin
                        step_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        step_d = step_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                state_d   = S_TB;
                rd_act_d  = 1'b1;
                rd_addr_d = LAST;
            end
            S_TB: begin
                if (rd_act_q) begin
                    rd_dly_v_d    = 1'b1;
                    rd_dly_addr_d = rd_addr_q;
                    if (rd_addr_q == '0) begin
                        rd_act_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q - ONE;
                    end
                end
                if (tb_bit_valid && rd_dly_v_q) begin
                    bit_buf_d[rd_dly_addr_q] = tb_bit;
                    if (rd_dly_addr_q == '0) begin
                        state_d = S_OUT;
                        idx_d   = '0;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        state_d = S_ACS;
                        idx_d   = '0;
                        step_d  = '0;
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
            end
            default: state_d = S_ACS;
        endcase
    end

    // Output decode; everything is forced low while reset is sampled.
    always_comb begin
        in_ready    = 1'b0;
        bmc_rx_pair = 2'b00;
        acs_en      = 1'b0;
        pm_init     = 1'b0;
        sm_wr_en    = 1'b0;
        sm_rd_en    = 1'b0;
        sm_addr     = '0;
        tb_start    = 1'b0;
        out_valid   = 1'b0;
        out_bit     = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            busy = !((state_q == S_ACS) && (step_q == '0));
            // A pending write only exists in ACS or in the single DRAIN cycle.
            sm_wr_en = wr_pend_q;
            if (wr_pend_q) begin
                sm_addr = wr_addr_q;
            end
            unique case (state_q)
                S_ACS: begin
                    in_ready = 1'b1;
                    if (accept) begin
                        acs_en      = 1'b1;
                        bmc_rx_pair = in_rx_pair;
                        pm_init     = (step_q == '0);
                    end
                end
                S_TB: begin
                    if (rd_act_q) begin
                        sm_rd_en = 1'b1;
                        sm_addr  = rd_addr_q;
                        tb_start = (rd_addr_q == LAST);
                    end
                end
                S_OUT: begin
                    out_valid = 1'b1;
                    out_bit   = bit_buf_q[idx_q];
                    out_last  = (idx_q == LAST);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl (FRAME_LEN = 8).
// Stimulus pushes expected ACS strobes, survivor writes, traceback reads and
// decoded bits into queues; a negedge monitor pops and compares them
// whenever the DUT presents the matching output.
module tb_viterbi_frame_ctrl;

    localparam int FL = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b1;
    logic [1:0]    in_rx_pair = 2'b01;
    logic          in_ready;
    logic [1:0]    bmc_rx_pair;
    logic          acs_en, pm_init, sm_wr_en, sm_rd_en, tb_start;
    logic [AW-1:0] sm_addr;
    logic          tb_bit_valid = 1'b0;
    logic          tb_bit = 1'b0;
    logic          out_valid, out_bit, out_last;
    logic          out_ready = 1'b0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]    q_acs[$];   // {pair, pm_init}
    logic [AW-1:0] q_wr[$];    // write address
    logic [AW:0]   q_rd[$];    // {tb_start, read address}
    logic [1:0]    q_out[$];   // {bit, last}

    logic [FL-1:0] tb_model = '0;  // traceback bit per survivor address
    logic          stale_force = 1'b0;
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_a = '0;

    logic [14:0] all_out;
    assign all_out = {in_ready, bmc_rx_pair, acs_en, pm_init, sm_wr_en, sm_rd_en,
                      sm_addr, tb_start, out_valid, out_bit, out_last, busy};

    viterbi_frame_ctrl #(.FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rx_pair(in_rx_pair), .in_ready(in_ready),
        .bmc_rx_pair(bmc_rx_pair), .acs_en(acs_en), .pm_init(pm_init),
        .sm_wr_en(sm_wr_en), .sm_rd_en(sm_rd_en), .sm_addr(sm_addr),
        .tb_start(tb_start), .tb_bit_valid(tb_bit_valid), .tb_bit(tb_bit),
        .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Traceback model: answers each read one cycle later with the bit stored
    // for that address; stale_force injects spurious returns.
    always @(negedge clk) begin
        pend_v = sm_rd_en;
        pend_a = sm_addr;
    end
    always @(posedge clk) begin
        #2;
        tb_bit_valid = pend_v | stale_force;
        tb_bit       = pend_v ? tb_model[pend_a] : stale_force;
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    logic prev_v = 1'b0, prev_r = 1'b0, prev_b = 1'b0, prev_l = 1'b0;
    always @(negedge clk) begin
        if (acs_en) begin
            if (q_acs.size() == 0) check("acs_unexpected", 1, 0);
            else check("acs_pair_pm", {29'd0, bmc_rx_pair, pm_init}, {29'd0, q_acs.pop_front()});
        end
        if (sm_wr_en) begin
            if (q_wr.size() == 0) check("wr_unexpected", 1, 0);
            else check("wr_addr", {29'd0, sm_addr}, {29'd0, q_wr.pop_front()});
        end
        if (sm_rd_en) begin
            if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_start_addr", {28'd0, tb_start, sm_addr}, {28'd0, q_rd.pop_front()});
        end
        if (out_valid && out_ready) begin
            if (q_out.size() == 0) check("out_unexpected", 1, 0);
            else check("out_bit_last", {30'd0, out_bit, out_last}, {30'd0, q_out.pop_front()});
        end
        if (prev_v && !prev_r)
            check("out_hold", {29'd0, out_valid, out_bit, out_last}, {29'd0, 1'b1, prev_b, prev_l});
        prev_v = out_valid;
        prev_r = out_ready;
        prev_b = out_bit;
        prev_l = out_last;
    end

    task automatic flush_queues();
        q_acs.delete();
        q_wr.delete();
        q_rd.delete();
        q_out.delete();
    endtask

    // One frame: pairs[2i+:2] is beat i, bits[a] is the traceback bit for
    // address a. bp_idx < 0 disables output backpressure.
    task automatic run_frame(input logic [15:0] pairs, input bit stall,
                             input int bp_idx, input logic [7:0] bits, input bit abort);
        int  n_acc;
        int  hold;
        bit  acc;
        tb_model = bits;
        for (int a = FL - 1; a >= 0; a--)
            q_rd.push_back({(a == FL - 1) ? 1'b1 : 1'b0, AW'(a)});
        for (int a = 0; a < FL; a++)
            q_out.push_back({bits[a], (a == FL - 1) ? 1'b1 : 1'b0});
        for (int i = 0; i < FL; i++) begin
            @(posedge clk); #1;
            check("in_ready_acs", {31'd0, in_ready}, 1);
            in_valid   = 1'b1;
            in_rx_pair = pairs[2*i +: 2];
            q_acs.push_back({pairs[2*i +: 2], (i == 0) ? 1'b1 : 1'b0});
            q_wr.push_back(AW'(i));
            if (stall && i < FL - 1) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        // DRAIN: input offered but must not be taken.
        @(posedge clk); #1;
        check("drain_in_ready", {31'd0, in_ready}, 0);
        check("drain_busy", {31'd0, busy}, 1);
        in_valid   = 1'b1;
        in_rx_pair = 2'b11;
        if (abort) begin
            for (int c = 0; c < 40 && !(sm_rd_en && sm_addr == 3'd3); c++) begin
                @(posedge clk); #1;
            end
            check("abort_reached_rd3", {31'd0, sm_rd_en}, 1);
            rst      = 1'b1;
            in_valid = 1'b0;
            flush_queues();
            #1;
            check("abort_rst_outputs0", {17'd0, all_out}, 0);
            @(posedge clk); #1;
            check("abort_rst_outputs0_b", {17'd0, all_out}, 0);
            rst = 1'b0;
            #1;
            check("abort_post_in_ready", {31'd0, in_ready}, 1);
            check("abort_post_busy", {31'd0, busy}, 0);
            return;
        end
        for (int c = 0; c < 40 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        check("out_valid_reached", {31'd0, out_valid}, 1);
        in_valid = 1'b0;
        n_acc = 0;
        hold  = 0;
        for (int c = 0; c < 60 && n_acc < FL; c++) begin
            out_ready = !(n_acc == bp_idx && hold < 3);
            if (!out_ready) hold++;
            #1;
            acc = out_valid && out_ready;
            @(posedge clk); #1;
            if (acc) n_acc++;
        end
        out_ready = 1'b0;
        check("out_accept_count", n_acc, FL);
        check("ret_in_ready", {31'd0, in_ready}, 1);
        check("ret_busy", {31'd0, busy}, 0);
        check("ret_out_valid", {31'd0, out_valid}, 0);
    endtask

    initial begin
        // Reset held three cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_outputs0", {17'd0, all_out}, 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 1);
        check("post_reset_busy", {31'd0, busy}, 0);

        // Back-to-back frame; bits for addrs 7..0 = 1,0,0,1,1,1,0,1.
        run_frame(16'h1B6C, 1'b0, -1, 8'b1001_1101, 1'b0);
        // Alternating input stalls.
        run_frame(16'hE4D2, 1'b1, -1, 8'b0110_0011, 1'b0);
        // Output backpressure on idx 4.
        run_frame(16'h3A95, 1'b0, 4, 8'b1010_0101, 1'b0);
        // Reset during traceback read of addr 3.
        run_frame(16'h5F0C, 1'b0, -1, 8'b1100_1010, 1'b1);

        // Stale traceback returns in ACS must be ignored.
        stale_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stale_busy", {31'd0, busy}, 0);
        end
        stale_force = 1'b0;
        @(posedge clk); #1;
        run_frame(16'h8E71, 1'b0, -1, 8'b1111_0000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queues_drained", q_acs.size() + q_wr.size() + q_rd.size() + q_out.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
